univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 72 +++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / forward / backward / parallel load, with frame counting.
// Optional SHIFT_ROTATE_EN macro adds end-around recirculation on shifts when rotate=1.
module univ_shift_reg #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         serial_in_fwd,
    input  logic                         serial_in_bwd,
    input  logic                         rotate,
    input  logic [WIDTH-1:0]             parallel_in,
    output logic [WIDTH-1:0]             parallel_out,
    output logic                         serial_out_fwd,
    output logic                         serial_out_bwd,
    output logic [$clog2(WIDTH+1)-1:0]   shift_count,
    output logic                         frame_done
);
    localparam int CW = $clog2(WIDTH+1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_BWD  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] stages;
    logic             fwd_in;
    logic             bwd_in;
    logic             is_shift;
    logic             frame_end;

`ifdef SHIFT_ROTATE_EN
    assign fwd_in = rotate ? stages[WIDTH-1] : serial_in_fwd;
    assign bwd_in = rotate ? stages[0]       : serial_in_bwd;
`else
    logic unused_rotate;
    assign unused_rotate = rotate;
    assign fwd_in        = serial_in_fwd;
    assign bwd_in        = serial_in_bwd;
`endif

    assign is_shift  = (mode == MODE_FWD) || (mode == MODE_BWD);
    assign frame_end = (shift_count == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            stages      <= RESET_VALUE;
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            // Direction does not matter for framing: any shift advances the same counter.
            frame_done <= is_shift && frame_end;
            if (is_shift)
                shift_count <= frame_end ? '0 : shift_count + CW'(1);
            case (mode)
                MODE_FWD:  stages <= {stages[WIDTH-2:0], fwd_in};
                MODE_BWD:  stages <= {bwd_in, stages[WIDTH-1:1]};
                MODE_LOAD: begin
                    stages      <= parallel_in;
                    shift_count <= '0;
                end
                MODE_HOLD: stages <= stages;
                default:   stages <= stages;
            endcase
        end
    end

    assign parallel_out   = stages;
    assign serial_out_fwd = stages[WIDTH-1];
    assign serial_out_bwd = stages[0];
endmodule
